// File: rtl/tdm_mux_16x1_pkg.sv
// Shared constants and types for the 16-channel TDM transmitter.
// Used by the interface, the channel counter and the top level.
package tdm_pkg;

   localparam int N_CH  = 16;
   localparam int SEL_W = 4;

   localparam logic [SEL_W-1:0] CH_FIRST = 4'd0;
   localparam logic [SEL_W-1:0] CH_LAST  = 4'd15;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tdm_state_e;

endpackage

// File: rtl/tdm_mux_16x1_if.sv
// Parallel-request and serial valid/ready bundle between the frame source,
// the TDM transmitter and the downstream demultiplexer.
interface tdm_mux_16x1_if;
   import tdm_pkg::*;

   logic             start;
   logic [N_CH-1:0]  din;
   logic             ready;
   logic             y;
   logic [SEL_W-1:0] sel;
   logic             valid;
   logic             sof;
   logic             eof;
   logic             busy;
   logic             done;

   // The source/sink side that drives requests and back-pressure.
   modport master (
      output start, din, ready,
      input  y, sel, valid, sof, eof, busy, done
   );

   // The transmitter itself.
   modport slave (
      input  start, din, ready,
      output y, sel, valid, sof, eof, busy, done
   );

endinterface

// File: rtl/tdm_mux_16x1_chan_cnt.sv
// Four-bit channel index with synchronous clear and increment enable.
// Saturates at the last channel; the parent handles leaving channel 15 via clear.
module tdm_chan_cnt
   import tdm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [SEL_W-1:0] cnt_o,
   output logic [SEL_W-1:0] cnt_next_o,
   output logic             is_last_o
);

   logic [SEL_W-1:0] cnt_q;
   logic [SEL_W-1:0] cnt_d;

   // Next value is exported so the parent can register outputs from it.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = CH_FIRST;
      end else if (inc_i && (cnt_q != CH_LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= CH_FIRST;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign cnt_next_o = cnt_d;
   assign is_last_o  = (cnt_q == CH_LAST);

endmodule

// File: rtl/tdm_mux_16x1.sv
// Sixteen-channel TDM transmitter: captures a 16-bit word on start and
// serialises it one channel per accepted beat, with all outputs registered.
module tdm_mux_16x1
   import tdm_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   tdm_mux_16x1_if.slave  bus
);

   tdm_state_e       state_q;
   tdm_state_e       state_d;
   logic [N_CH-1:0]  shadow_q;
   logic [N_CH-1:0]  shadow_d;

   logic             y_q;
   logic             y_d;
   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] sel_d;
   logic             valid_q;
   logic             valid_d;
   logic             sof_q;
   logic             sof_d;
   logic             eof_q;
   logic             eof_d;
   logic             busy_q;
   logic             busy_d;
   logic             done_q;
   logic             done_d;

   logic             accept;
   logic             capture;
   logic             cntClr;
   logic             cntInc;
   logic             isLast;
   logic [SEL_W-1:0] cnt;
   logic [SEL_W-1:0] cntNext;

   tdm_chan_cnt u_chan_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (cntClr),
      .inc_i      (cntInc),
      .cnt_o      (cnt),
      .cnt_next_o (cntNext),
      .is_last_o  (isLast)
   );

   assign accept = (state_q == SEND) && bus.ready;

   // Frame sequencing; a start on the channel-15 acceptance chains the next frame.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      cntClr  = 1'b0;
      cntInc  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = SEND;
               capture = 1'b1;
               cntClr  = 1'b1;
            end
         end
         SEND: begin
            if (accept) begin
               if (isLast) begin
                  done_d = 1'b1;
                  cntClr = 1'b1;
                  if (bus.start) begin
                     capture = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cntInc = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign shadow_d = capture ? bus.din : shadow_q;

   // Output next-values come from next state/counter so every output is a flop.
   always_comb begin
      y_d     = 1'b0;
      sel_d   = '0;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      busy_d  = 1'b0;
      if (state_d == SEND) begin
         y_d     = shadow_d[cntNext];
         sel_d   = cntNext;
         valid_d = 1'b1;
         sof_d   = (cntNext == CH_FIRST);
         eof_d   = (cntNext == CH_LAST);
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         y_q      <= 1'b0;
         sel_q    <= '0;
         valid_q  <= 1'b0;
         sof_q    <= 1'b0;
         eof_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         y_q      <= y_d;
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         sof_q    <= sof_d;
         eof_q    <= eof_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.y     = y_q;
   assign bus.sel   = sel_q;
   assign bus.valid = valid_q;
   assign bus.sof   = sof_q;
   assign bus.eof   = eof_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_tdm_mux_16x1.sv
// Self-checking bench for tdm_mux_16x1: vector table for a plain frame plus
// stall, back-to-back, mid-frame reset and random loopback sequences.
module tb_tdm_mux_16x1;
   import tdm_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   tdm_mux_16x1_if bus();

   tdm_mux_16x1 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic        start;
      logic [15:0] din;
      logic        ready;
      logic [9:0]  expOut;
   } vec_t;

   vec_t vecs[18];

   // Output pack order: {y, sel[3:0], valid, sof, eof, busy, done}.
   function automatic logic [9:0] beat(input logic [15:0] w, input int ch, input logic dn);
      logic [3:0] s;
      s = 4'(ch);
      return {w[s], s, 1'b1, (ch == 0), (ch == 15), 1'b1, dn};
   endfunction

   function automatic logic [9:0] idleOut(input logic dn);
      return {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, dn};
   endfunction

   task automatic checkOutput(input string name, input logic [9:0] expv);
      logic [9:0] act;
      act = {bus.y, bus.sel, bus.valid, bus.sof, bus.eof, bus.busy, bus.done};
      total++;
      if (act !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got %b want %b (y,sel,valid,sof,eof,busy,done)", name, act, expv);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [15:0] d, input logic rdy);
      bus.start = st;
      bus.din   = d;
      bus.ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] w;
      logic [15:0] recon;
      logic        rdy;
      logic        got;
      int          ch;
      int          stall;
      int          cycles;

      bus.start = 1'b0;
      bus.din   = '0;
      bus.ready = 1'b0;
      #1;
      checkOutput("reset state", idleOut(1'b0));
      @(negedge clk);
      rst_n = 1'b1;

      // Plain frame, ready always high; din is scrambled after capture on purpose.
      w = 16'hA5C3;
      vecs[0] = '{1'b1, w, 1'b1, beat(w, 0, 1'b0)};
      for (int i = 1; i < 16; i++) begin
         vecs[i] = '{1'b0, 16'h0000, 1'b1, beat(w, i, 1'b0)};
      end
      vecs[16] = '{1'b0, 16'h0000, 1'b1, idleOut(1'b1)};
      vecs[17] = '{1'b0, 16'h0000, 1'b1, idleOut(1'b0)};
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].start, vecs[i].din, vecs[i].ready);
         checkOutput($sformatf("table vec %0d", i), vecs[i].expOut);
      end

      // Two-cycle stalls on channels 3 and 9.
      applyStimulus(1'b1, w, 1'b0);
      checkOutput("stall capture", beat(w, 0, 1'b0));
      ch = 0;
      stall = 0;
      cycles = 0;
      while (ch < 16 && cycles < 40) begin
         rdy = ((ch == 3 || ch == 9) && stall < 2) ? 1'b0 : 1'b1;
         applyStimulus(1'b0, 16'h1234, rdy);
         cycles++;
         if (rdy) begin
            ch++;
            stall = 0;
         end else begin
            stall++;
         end
         if (ch < 16) checkOutput($sformatf("stall cyc %0d", cycles), beat(w, ch, 1'b0));
         else         checkOutput("stall end", idleOut(1'b1));
      end
      total++;
      if (cycles != 20) begin
         bad++;
         $display("[TB] FAIL stall frame length: got %0d want 20", cycles);
      end

      // Back-to-back frames with start held high and din changed mid-frame.
      applyStimulus(1'b1, 16'hA5C3, 1'b1);
      checkOutput("b2b first ch0", beat(16'hA5C3, 0, 1'b0));
      for (int i = 1; i < 16; i++) begin
         applyStimulus(1'b1, (i >= 8) ? 16'h0F0F : 16'hA5C3, 1'b1);
         checkOutput($sformatf("b2b first ch%0d", i), beat(16'hA5C3, i, 1'b0));
      end
      applyStimulus(1'b1, 16'h0F0F, 1'b1);
      checkOutput("b2b second ch0", beat(16'h0F0F, 0, 1'b1));
      for (int i = 1; i < 16; i++) begin
         applyStimulus(1'b0, 16'hFFFF, 1'b1);
         checkOutput($sformatf("b2b second ch%0d", i), beat(16'h0F0F, i, 1'b0));
      end
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("b2b end", idleOut(1'b1));

      // Asynchronous reset at beat 7, then a fresh all-ones frame.
      applyStimulus(1'b1, 16'hA5C3, 1'b1);
      for (int i = 1; i < 8; i++) begin
         applyStimulus(1'b0, 16'h0000, 1'b1);
      end
      checkOutput("pre-reset ch7", beat(16'hA5C3, 7, 1'b0));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset", idleOut(1'b0));
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("reset no done", idleOut(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 16'hFFFF, 1'b1);
      checkOutput("post-reset ch0", beat(16'hFFFF, 0, 1'b0));
      for (int i = 1; i < 16; i++) begin
         applyStimulus(1'b0, 16'h0000, 1'b1);
         checkOutput($sformatf("post-reset ch%0d", i), beat(16'hFFFF, i, 1'b0));
      end
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("post-reset end", idleOut(1'b1));

      // Loopback through a behavioural 1x16 demultiplexer with random back-pressure.
      for (int f = 0; f < 200; f++) begin
         w = 16'($urandom);
         applyStimulus(1'b1, w, 1'($urandom_range(0, 1)));
         recon = '0;
         got = 1'b0;
         cycles = 0;
         while (!got && cycles < 200) begin
            rdy = 1'($urandom_range(0, 1));
            if (bus.valid && rdy) begin
               recon[bus.sel] = bus.y;
               if (bus.eof) got = 1'b1;
            end
            applyStimulus(1'b0, 16'($urandom), rdy);
            cycles++;
         end
         total++;
         if (!got || recon !== w) begin
            bad++;
            $display("[TB] FAIL loopback frame %0d: got %h want %h (complete=%0d)", f, recon, w, got);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tdm_mux_16x1.md
# tdm_mux_16x1

Sixteen-channel time-division multiplexer: on request it captures a 16-bit parallel word and emits it one bit per accepted beat, with a 4-bit channel select attached to each bit. It is the transmit end of the 1x16 demultiplexer path. The serial bit `y` and `sel` feed the demultiplexer's data and select inputs, with `sel[3]` driving the most-significant select. Downstream flow control uses a valid/ready handshake.

## Interface
- `N_CH`, 16, number of channels; fixed at 16 for this revision.
- `SEL_W`, 4, select width, equal to log2(`N_CH`).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to capture `din` and send a frame.
- `din`  in  16  parallel word; bit i is sent on channel i.
- `ready`  in  1  downstream accepts the current beat.
- `y`  out  1  serial data bit for the current beat, registered.
- `sel`  out  4  channel index of the current beat, registered; `sel[3]` is the MSB.
- `valid`  out  1  `y` and `sel` are valid.
- `sof`  out  1  high with the channel-0 beat.
- `eof`  out  1  high with the channel-15 beat.
- `busy`  out  1  frame in progress; `start` is ignored while high, except on the final handshake.
- `done`  out  1  one-cycle pulse after channel 15 is accepted.

## Operation
- States:
  - IDLE: `busy`=0, `valid`=0.
  - SEND: `busy`=1, `valid`=1.
- IDLE → SEND when `start`=1.
  - The same edge copies `din` into a 16-bit shadow register and clears the channel counter to 0.
- In SEND:
  - `y` = shadow[counter] and `sel` = counter.
  - `sof` = (counter==0) and `eof` = (counter==15).
- Handshake: a beat is accepted on any edge where `valid`&&`ready`.
  - On acceptance the counter increments.
  - Without acceptance, `y`, `sel`, `sof`, `eof` and `valid` hold stable. There is no timeout.
- Accepting channel 15:
  - `done` pulses for the next cycle.
  - With `start`=0, the block returns to IDLE.
  - With `start`=1 on that same edge, `din` is recaptured and the block stays in SEND with counter=0. Frames go back-to-back with no bubble, and `done` still pulses.
- `start` in SEND other than on the channel-15 acceptance edge is ignored. No capture occurs and no error is flagged.
- `din` is sampled only on the capture edge. Later changes do not affect the frame in flight.
- The counter is 4 bits and never wraps past 15 within a frame. Leaving channel 15 always goes through the end-of-frame rule above.
- `ready` has no effect while in IDLE.

## Timing
- Reset (asynchronous assert): state=IDLE, counter=0, shadow=0, and all outputs 0 (`y`, `sel`, `valid`, `sof`, `eof`, `busy`, `done`).
  - Reset mid-frame discards the frame and produces no `done`.
  - Deassertion is synchronized externally. The first active edge after release may capture `start`.
- Latency: `start` sampled at edge T gives `valid`=1, `sel`=0, `sof`=1 from edge T+1.
- With `ready` held at 1, a frame takes exactly 16 cycles. `done` is high in cycle 17 after capture.
- All outputs are registered. There is no combinational path from `ready` or `start` to any output.

## Structure
- Shared package `tdm_pkg` contains:
  - the `N_CH` and `SEL_W` constants;
  - the state enum {IDLE, SEND};
  - the constants `CH_FIRST`=0 and `CH_LAST`=15.
- One sub-module: `tdm_chan_cnt`, a 4-bit counter.
  - Inputs: synchronous clear, increment enable.
  - Outputs: `is_last` flag.
  - Its reset is the same asynchronous active-low reset as the parent.
- The top level holds the FSM, the shadow register and the output registers.

## Test plan
- `din`=16'hA5C3, `start` pulse, `ready`=1 → 16 beats; `y` sequence is bits 0..15 of 16'hA5C3; `sel` runs 0..15; `sof` on beat 0, `eof` on beat 15; `done` pulses in cycle 17; then IDLE.
- Same frame with `ready` low on beats 3 and 9 for 2 cycles each → outputs stay stable during each stall; the frame completes in 20 cycles with no dropped or duplicated channel.
- `start` held high with `din` changed to 16'h0F0F mid-frame → the first frame is unaffected. The second frame begins on the cycle after channel 15, with no bubble and `sof`=1.
- `rst_n` asserted at beat 7 → all outputs go to 0 immediately with no `done`. After release, a new `start` sends 16'hFFFF correctly from channel 0.
- Loopback through the 1x16 demultiplexer for 200 random words with random `ready` → the reconstructed word equals `din` every frame.
